fp_regfile_fwd: RTL and testbench
=================================

# fp_regfile_fwd

Floating-point register file with operand forwarding and RAW-hazard stall detection, sitting in the ID stage directly upstream of the pipelined FPU. It supplies the two 32-bit operands `a`/`b` the FPU latches into its E1 registers. It absorbs the FPU's W-stage write-back (`wn`/`wd`/`ww`) and forwards the E3 result (`ed`). It raises `stall_fp` when a source register is still in flight in E1 or E2.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `clrn`  in  1  asynchronous active-low reset
- `fs`  in  5  source register number for operand a
- `ft`  in  5  source register number for operand b
- `use_fs`  in  1  current instruction reads fs
- `use_ft`  in  1  current instruction reads ft
- `e1n`, `e2n`, `e3n`  in  5 each  destination register numbers of E1/E2/E3
- `e1w`, `e2w`, `e3w`  in  1 each  E1/E2/E3 will write the FP register file
- `ed`  in  32  E3 result, taken before the W register
- `wn`  in  5  W-stage destination register
- `wd`  in  32  W-stage result
- `ww`  in  1  W-stage write enable
- `a`  out  32  operand a to FPU
- `b`  out  32  operand b to FPU
- `fwdfa`  out  2  source select for a: 0 = regfile, 1 = E3 (`ed`), 2 = W (`wd`)
- `fwdfb`  out  2  same encoding for b
- `stall_fp`  out  1  RAW hazard; hold IF/ID, bubble E1
- `stall_cnt`  out  16  stall cycle count (see Configuration)

## Operation
- Storage is 32 × 32-bit. All registers are writable, including register 0.
- Write: on a rising `clk` edge with `ww`=1, `reg[wn]` <= `wd`. The write is repeated harmlessly while the W stage is held.
- Operand a source select, highest priority first:
  - `e3w & e3n==fs` → `ed`, `fwdfa`=1
  - else `ww & wn==fs` → `wd`, `fwdfa`=2
  - else `reg[fs]`, `fwdfa`=0
- Operand b uses the same selection with `ft`/`fwdfb`.
- W forwarding gives write-through. A same-cycle read of the register being written returns `wd`, never the old value.
- Hazard: `stall_fp` = (`use_fs` & ((`e1w` & `e1n`==fs) | (`e2w` & `e2n`==fs))) | (`use_ft` & (same terms with ft)).
- `stall_fp` is purely combinational and has no state. Results in E1/E2 cannot be forwarded; they are waited out.
- The forward and stall decisions ignore `use_fs`/`use_ft` for the data path. `a`/`b` are always driven.
- fdiv/fsqrt stalls are handled by the FPU (`st_ds`) and are not this block's concern. Both stall sources are ORed externally.

## Timing
- `a`/`b`/`fwdfa`/`fwdfb`/`stall_fp` are combinational from inputs and current storage, with zero latency.
- A write at edge N is visible through storage at edge N+1 and later. In the cycle before edge N it is visible via W forwarding.
- Back-to-back dependent FPU ops (each E1→E2→E3→W takes one cycle):
  - consumer stalls 2 cycles
  - then takes `ed` when the producer reaches E3
- Reset (`clrn`=0, any time, including mid-stall):
  - all 32 registers clear to 0 immediately
  - `stall_cnt` clears to 0
  - combinational outputs then reflect the zeroed storage and the current inputs
- Simultaneous E3 and W hits on the same register: E3 wins, because it is the younger instruction.
- Both operands naming the same register: both get the identical source.

## Configuration
- Macro `FP_STALL_CNT_EN`.
- Defined:
  - `stall_cnt` increments by 1 on every rising edge where `stall_fp`=1
  - it saturates at 16'hFFFF and does not wrap
  - it resets to 0 on `clrn`=0
- Undefined: the counter logic is absent and `stall_cnt` is tied to 16'h0000.
- Hazard and forwarding behaviour is identical either way.

## Test plan
- Reset then read: pulse `clrn`=0, fs=3, ft=31, no hits → `a`=0, `b`=0, `fwdfa`=`fwdfb`=0, `stall_fp`=0.
- Write-through: `ww`=1, `wn`=5, `wd`=32'h3F800000, fs=5 → `a`=32'h3F800000, `fwdfa`=2. After the edge with `ww`=0 → `a`=32'h3F800000, `fwdfa`=0.
- E3 priority: `e3w`=1, `e3n`=7, `ed`=32'h40000000; `ww`=1, `wn`=7, `wd`=32'h3F800000; ft=7 → `b`=32'h40000000, `fwdfb`=1.
- RAW stall: `e1w`=1, `e1n`=2, fs=2, `use_fs`=1 → `stall_fp`=1. With `use_fs`=0 → `stall_fp`=0. With `e2w`=1, `e2n`=2, ft=2, `use_ft`=1 → `stall_fp`=1.
- Dependent add→mul sequence driven through the FPU pipeline model → exactly 2 stall cycles, then `fwdfa`=1 with the correct sum.
- With `FP_STALL_CNT_EN`: hold `stall_fp`=1 for 70000 cycles → `stall_cnt`=16'hFFFF. Then `clrn`=0 → `stall_cnt`=0.

Source files
------------

// File: rtl/fp_regfile_fwd.sv
// FP register file (32 x 32) with E3/W operand forwarding and E1/E2 RAW stall detect.
// Latency: operand/select/stall outputs are combinational; writes land in storage at the next clk edge.
// Backpressure: stall_fp holds IF/ID and bubbles E1; optional stall counter under `FP_STALL_CNT_EN`.
module fp_regfile_fwd (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  fs,
  input  logic [4:0]  ft,
  input  logic        use_fs,
  input  logic        use_ft,
  input  logic [4:0]  e1n,
  input  logic [4:0]  e2n,
  input  logic [4:0]  e3n,
  input  logic        e1w,
  input  logic        e2w,
  input  logic        e3w,
  input  logic [31:0] ed,
  input  logic [4:0]  wn,
  input  logic [31:0] wd,
  input  logic        ww,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [1:0]  fwdfa,
  output logic [1:0]  fwdfb,
  output logic        stall_fp,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] SRC_RF = 2'd0;
  localparam logic [1:0] SRC_E3 = 2'd1;
  localparam logic [1:0] SRC_W  = 2'd2;

  logic [31:0] regs_q [32];

  // Storage write from the W stage; every register (including 0) is writable.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (ww) begin
      regs_q[wn] <= wd;
    end
  end

  // Operand a select: E3 is younger than W, so it wins; W gives write-through.
  always_comb begin
    fwdfa = SRC_RF;
    a     = regs_q[fs];
    if (e3w && (e3n == fs)) begin
      fwdfa = SRC_E3;
      a     = ed;
    end else if (ww && (wn == fs)) begin
      fwdfa = SRC_W;
      a     = wd;
    end
  end

  // Operand b select, same priority as operand a.
  always_comb begin
    fwdfb = SRC_RF;
    b     = regs_q[ft];
    if (e3w && (e3n == ft)) begin
      fwdfb = SRC_E3;
      b     = ed;
    end else if (ww && (wn == ft)) begin
      fwdfb = SRC_W;
      b     = wd;
    end
  end

  // Results still in E1/E2 are not available yet, so a reader must wait them out.
  always_comb begin
    stall_fp = (use_fs && ((e1w && (e1n == fs)) || (e2w && (e2n == fs)))) ||
               (use_ft && ((e1w && (e1n == ft)) || (e2w && (e2n == ft))));
  end

`ifdef FP_STALL_CNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Saturating count of stalled cycles; never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_fp && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fp_regfile_fwd.sv
module tb_fp_regfile_fwd;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [4:0]  fs, ft, e1n, e2n, e3n, wn;
  logic        use_fs, use_ft, e1w, e2w, e3w, ww;
  logic [31:0] ed, wd;
  logic [31:0] a, b;
  logic [1:0]  fwdfa, fwdfb;
  logic        stall_fp;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [31:0] rf_m [32];
  int          cnt_m = 0;

  fp_regfile_fwd dut (
    .clk(clk), .clrn(clrn), .fs(fs), .ft(ft), .use_fs(use_fs), .use_ft(use_ft),
    .e1n(e1n), .e2n(e2n), .e3n(e3n), .e1w(e1w), .e2w(e2w), .e3w(e3w),
    .ed(ed), .wn(wn), .wd(wd), .ww(ww),
    .a(a), .b(b), .fwdfa(fwdfa), .fwdfb(fwdfb), .stall_fp(stall_fp), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  fs, ft;
    logic        use_fs, use_ft;
    logic [4:0]  e1n, e2n, e3n;
    logic        e1w, e2w, e3w;
    logic [31:0] ed;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic        ww;
    logic [31:0] xa, xb;
    logic [1:0]  xfa, xfb;
    logic        xstall;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    fs = 0; ft = 0; use_fs = 0; use_ft = 0;
    e1n = 0; e2n = 0; e3n = 0; e1w = 0; e2w = 0; e3w = 0;
    ed = 0; wn = 0; wd = 0; ww = 0;
  endtask

  // Operand value as the spec defines it: youngest available producer first.
  function automatic logic [33:0] model_operand(input logic [4:0] r);
    if (e3w && e3n == r) return {2'd1, ed};
    if (ww && wn == r)   return {2'd2, wd};
    return {2'd0, rf_m[r]};
  endfunction

  // Stall if any read source is among the destinations still in E1/E2.
  function automatic logic model_stall();
    logic [4:0] pend[$];
    if (e1w) pend.push_back(e1n);
    if (e2w) pend.push_back(e2n);
    foreach (pend[i]) begin
      if (use_fs && pend[i] == fs) return 1'b1;
      if (use_ft && pend[i] == ft) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_cnt();
`ifdef FP_STALL_CNT_EN
    return cnt_m[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_model(input string nm);
    logic [33:0] oa, ob;
    #1;
    oa = model_operand(fs);
    ob = model_operand(ft);
    cmp({nm, ".a"}, a, oa[31:0]);
    cmp({nm, ".b"}, b, ob[31:0]);
    cmp({nm, ".fwdfa"}, {30'd0, fwdfa}, {30'd0, oa[33:32]});
    cmp({nm, ".fwdfb"}, {30'd0, fwdfb}, {30'd0, ob[33:32]});
    cmp({nm, ".stall"}, {31'd0, stall_fp}, {31'd0, model_stall()});
    cmp({nm, ".cnt"}, {16'd0, stall_cnt}, {16'd0, model_cnt()});
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    logic st;
    st = model_stall();
    if (ww) rf_m[wn] = wd;
    if (st && cnt_m < 65535) cnt_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    cnt_m = 0;
    #1;
    @(negedge clk);
    clrn = 1'b1;
  endtask

  function automatic vec_t mk(input string nm, input logic [4:0] fs_, ft_, input logic ufs, uft,
                              input logic [4:0] e1n_, input logic e1w_, input logic [4:0] e2n_, input logic e2w_,
                              input logic [4:0] e3n_, input logic e3w_, input logic [31:0] ed_,
                              input logic [4:0] wn_, input logic ww_, input logic [31:0] wd_,
                              input logic [31:0] xa_, xb_, input logic [1:0] xfa_, xfb_, input logic xs_);
    vec_t v;
    v.name = nm; v.fs = fs_; v.ft = ft_; v.use_fs = ufs; v.use_ft = uft;
    v.e1n = e1n_; v.e1w = e1w_; v.e2n = e2n_; v.e2w = e2w_; v.e3n = e3n_; v.e3w = e3w_; v.ed = ed_;
    v.wn = wn_; v.ww = ww_; v.wd = wd_; v.xa = xa_; v.xb = xb_; v.xfa = xfa_; v.xfb = xfb_; v.xstall = xs_;
    return v;
  endfunction

  // Pipeline model for the dependent-op sequence: index 1..3 = E1..E3, 4 = W.
  logic        pv  [1:4];
  logic [4:0]  pdst[1:4];
  logic [31:0] pres[1:4];

  task automatic drive_pipe();
    e1w = pv[1]; e1n = pdst[1];
    e2w = pv[2]; e2n = pdst[2];
    e3w = pv[3]; e3n = pdst[3]; ed = pv[3] ? pres[3] : 32'h0;
    ww  = pv[4]; wn  = pdst[4]; wd = pv[4] ? pres[4] : 32'h0;
  endtask

  task automatic adv_pipe(input logic nv, input logic [4:0] nd, input logic [31:0] nr);
    for (int s = 4; s > 1; s--) begin
      pv[s] = pv[s-1]; pdst[s] = pdst[s-1]; pres[s] = pres[s-1];
    end
    pv[1] = nv; pdst[1] = nd; pres[1] = nr;
  endtask

  initial begin
    int stalls;
    bit issued;
    clear_inputs();
    do_reset();

    // ---------------- table-driven combinational checks (storage all zero) ----
    vecs.push_back(mk("reset_read", 5'd3, 5'd31, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,
                      32'h0, 32'h0, 2'd0, 2'd0, 0));
    vecs.push_back(mk("wthru_comb", 5'd5, 5'd6, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'd5, 1, 32'h3F800000,
                      32'h3F800000, 32'h0, 2'd2, 2'd0, 0));
    vecs.push_back(mk("e3_prio", 5'd0, 5'd7, 0, 0, 0, 0, 0, 0, 5'd7, 1, 32'h40000000, 5'd7, 1, 32'h3F800000,
                      32'h0, 32'h40000000, 2'd0, 2'd1, 0));
    vecs.push_back(mk("raw_e1_fs", 5'd2, 5'd9, 1, 0, 5'd2, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,
                      32'h0, 32'h0, 2'd0, 2'd0, 1));
    vecs.push_back(mk("raw_e1_unused", 5'd2, 5'd9, 0, 0, 5'd2, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,
                      32'h0, 32'h0, 2'd0, 2'd0, 0));
    vecs.push_back(mk("raw_e2_ft", 5'd8, 5'd2, 0, 1, 0, 0, 5'd2, 1, 0, 0, 32'h0, 0, 0, 32'h0,
                      32'h0, 32'h0, 2'd0, 2'd0, 1));
    vecs.push_back(mk("e2_nowrite", 5'd8, 5'd2, 1, 1, 5'd2, 0, 5'd2, 0, 0, 0, 32'h0, 0, 0, 32'h0,
                      32'h0, 32'h0, 2'd0, 2'd0, 0));
    vecs.push_back(mk("same_reg", 5'd12, 5'd12, 1, 1, 0, 0, 0, 0, 5'd12, 1, 32'hC0A00000, 5'd12, 1, 32'h1,
                      32'hC0A00000, 32'hC0A00000, 2'd1, 2'd1, 0));
    vecs.push_back(mk("w_only_b", 5'd1, 5'd31, 0, 0, 0, 0, 0, 0, 5'd30, 1, 32'h5, 5'd31, 1, 32'hDEADBEEF,
                      32'h0, 32'hDEADBEEF, 2'd0, 2'd2, 0));

    foreach (vecs[i]) begin
      fs = vecs[i].fs; ft = vecs[i].ft; use_fs = vecs[i].use_fs; use_ft = vecs[i].use_ft;
      e1n = vecs[i].e1n; e1w = vecs[i].e1w; e2n = vecs[i].e2n; e2w = vecs[i].e2w;
      e3n = vecs[i].e3n; e3w = vecs[i].e3w; ed = vecs[i].ed;
      wn = vecs[i].wn; ww = vecs[i].ww; wd = vecs[i].wd;
      #1;
      cmp({vecs[i].name, ".a"}, a, vecs[i].xa);
      cmp({vecs[i].name, ".b"}, b, vecs[i].xb);
      cmp({vecs[i].name, ".fwdfa"}, {30'd0, fwdfa}, {30'd0, vecs[i].xfa});
      cmp({vecs[i].name, ".fwdfb"}, {30'd0, fwdfb}, {30'd0, vecs[i].xfb});
      cmp({vecs[i].name, ".stall"}, {31'd0, stall_fp}, {31'd0, vecs[i].xstall});
    end
    clear_inputs();
    #1;

    // ---------------- write-through then storage read ----
    ww = 1; wn = 5'd5; wd = 32'h3F800000; fs = 5'd5;
    #1;
    cmp("wt_before.a", a, 32'h3F800000);
    cmp("wt_before.fwdfa", {30'd0, fwdfa}, 32'd2);
    tick();
    ww = 0; wd = 32'h0;
    #1;
    cmp("wt_after.a", a, 32'h3F800000);
    cmp("wt_after.fwdfa", {30'd0, fwdfa}, 32'd0);
    // register 0 is writable
    ww = 1; wn = 5'd0; wd = 32'h12345678;
    tick();
    clear_inputs(); ft = 5'd0;
    #1;
    cmp("reg0.b", b, 32'h12345678);

    // ---------------- dependent fadd f3=f1+f2 -> fmul f4=f3*f1 ----
    clear_inputs();
    ww = 1; wn = 5'd1; wd = 32'h3F800000; tick();   // f1 = 1.0
    ww = 1; wn = 5'd2; wd = 32'h40000000; tick();   // f2 = 2.0
    clear_inputs();
    for (int s = 1; s <= 4; s++) begin pv[s] = 0; pdst[s] = 0; pres[s] = 0; end
    fs = 5'd1; ft = 5'd2; use_fs = 1; use_ft = 1;
    drive_pipe();
    check_model("dep_prod");
    tick();
    adv_pipe(1'b1, 5'd3, 32'h40400000);             // 1.0 + 2.0 = 3.0
    fs = 5'd3; ft = 5'd1;
    stalls = 0; issued = 0;
    for (int cyc = 0; cyc < 8 && !issued; cyc++) begin
      drive_pipe();
      #1;
      if (stall_fp) begin
        stalls++;
        tick();
        adv_pipe(1'b0, 5'd0, 32'h0);
      end else begin
        issued = 1;
        cmp("dep.stalls", stalls, 2);
        cmp("dep.fwdfa", {30'd0, fwdfa}, 32'd1);
        cmp("dep.a", a, 32'h40400000);
        cmp("dep.b", b, 32'h3F800000);
        tick();
      end
    end
    if (!issued) cmp("dep.timeout", 32'd0, 32'd1);
    clear_inputs();

    // ---------------- randomized against the reference model ----
    for (int it = 0; it < 400; it++) begin
      fs = 5'($urandom_range(0, 7)); ft = 5'($urandom_range(0, 7));
      use_fs = 1'($urandom); use_ft = 1'($urandom);
      e1n = 5'($urandom_range(0, 7)); e2n = 5'($urandom_range(0, 7)); e3n = 5'($urandom_range(0, 7));
      e1w = 1'($urandom); e2w = 1'($urandom); e3w = 1'($urandom);
      ed = $urandom; wd = $urandom; wn = 5'($urandom_range(0, 7)); ww = 1'($urandom);
      check_model("rand");
      tick();
    end
    clear_inputs();

    // ---------------- long stall / counter saturation ----
    fs = 5'd4; use_fs = 1; e1w = 1; e1n = 5'd4;
`ifdef FP_STALL_CNT_EN
    for (int i = 0; i < 70000; i++) tick();
    cmp("cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
`else
    for (int i = 0; i < 20; i++) tick();
    cmp("cnt_tied", {16'd0, stall_cnt}, 32'h0);
`endif

    // ---------------- reset mid-stall, between edges ----
    ww = 1; wn = 5'd4; wd = 32'hAAAA5555; tick(); ww = 0;
    @(negedge clk);
    #2;
    clrn = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    cnt_m = 0;
    #1;
    cmp("rst_mid.a", a, 32'h0);
    cmp("rst_mid.cnt", {16'd0, stall_cnt}, 32'h0);
    cmp("rst_mid.stall", {31'd0, stall_fp}, 32'd1);
    @(negedge clk);
    clrn = 1'b1;
    check_model("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
